// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
//
// Return-address stack for call/return prediction. Each retiring JAL/JALR
// is classified by its rd/rs1 against the link registers (x1, x5). Calls push
// their link address (pc_old + 4). Returns pop a predicted target. A
// coroutine-style JALR (rd and rs1 are different link registers) pops and then
// pushes.
//
// Parameters
//   XLEN      width of stored link/target addresses
//   DEPTH     number of entries (power of two, >= 2)
//   WRAP_MODE 1: a push on a full stack overwrites the oldest entry
//             0: a push on a full stack is dropped
//
// Ports
//   clk              in   core clock, rising edge
//   reset            in   asynchronous active-low reset
//   flush            in   synchronous clear of the stack (beats any op)
//   op_valid         in   jump presented this cycle
//   is_jal/is_jalr   in   instruction type (both or neither -> no op)
//   rd, rs1          in   register indices used for classification
//   link_addr        in   pc_old + 4 of the jump
//   tos_valid        out  stack non-empty (combinational from state)
//   tos_addr         out  top-of-stack value, 0 when empty
//   pop_target_valid out  one-cycle pulse after a successful pop
//   pop_target       out  target returned by the last successful pop
//   count            out  number of valid entries
//   overflow         out  one-cycle pulse after a push on a full stack
//   underflow        out  one-cycle pulse after a pop on an empty stack
//
// Handshake: there is no backpressure. An op is accepted in every cycle in
// which op_valid is high. Its effects appear on the state outputs right after
// the next rising edge, and the pulses are high for exactly that one cycle.
// -----------------------------------------------------------------------------
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       op_valid,
  input  logic                       is_jal,
  input  logic                       is_jalr,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [XLEN-1:0]            link_addr,
  output logic                       tos_valid,
  output logic [XLEN-1:0]            tos_addr,
  output logic                       pop_target_valid,
  output logic [XLEN-1:0]            pop_target,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage and pointers. sp_q points at the next free slot. Because DEPTH is
  // a power of two, PW-bit arithmetic on sp_q wraps modulo DEPTH by itself.
  logic [XLEN-1:0] entry_q [DEPTH];
  logic [PW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pop_target_q, pop_target_d;
  logic            ptv_q, ptv_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // Write port of the entry array.
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  // Decoded op for this cycle.
  logic            link_rd, link_rs1;
  logic            op_push, op_pop, op_pop_push;

  logic            empty, full;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] top_val;

  assign link_rd  = (rd  == 5'd1) || (rd  == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign top_idx = sp_q - PW'(1);
  assign top_val = entry_q[top_idx];

  // Classification. JALR with rd == rs1 (both link regs) is treated as a
  // plain call. Only distinct link registers mean pop-then-push.
  always_comb begin
    op_push     = 1'b0;
    op_pop      = 1'b0;
    op_pop_push = 1'b0;
    if (op_valid && (is_jal != is_jalr)) begin
      if (is_jal) begin
        op_push = link_rd;
      end else if (!link_rd && link_rs1) begin
        op_pop = 1'b1;
      end else if (link_rd && (!link_rs1 || (rd == rs1))) begin
        op_push = 1'b1;
      end else if (link_rd && link_rs1) begin
        op_pop_push = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    sp_d         = sp_q;
    count_d      = count_q;
    pop_target_d = pop_target_q;
    ptv_d        = 1'b0;
    ovf_d        = 1'b0;
    unf_d        = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = sp_q;

    if (flush) begin
      sp_d    = '0;
      count_d = '0;
    end else if (op_push) begin
      if (!full) begin
        wr_en   = 1'b1;
        sp_d    = sp_q + PW'(1);
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
        // With wrap, the slot at sp_q is the oldest entry when full, so
        // writing there drops the oldest entry and keeps count at DEPTH.
        if (WRAP_MODE != 0) begin
          wr_en = 1'b1;
          sp_d  = sp_q + PW'(1);
        end
      end
    end else if (op_pop) begin
      if (!empty) begin
        pop_target_d = top_val;
        ptv_d        = 1'b1;
        sp_d         = top_idx;
        count_d      = count_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (op_pop_push) begin
      if (!empty) begin
        // Replace the top in place. sp and count do not move.
        pop_target_d = top_val;
        ptv_d        = 1'b1;
        wr_en        = 1'b1;
        wr_idx       = top_idx;
      end else begin
        // The pop half underflows. The push half still lands.
        unf_d   = 1'b1;
        wr_en   = 1'b1;
        sp_d    = sp_q + PW'(1);
        count_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      sp_q         <= '0;
      count_q      <= '0;
      pop_target_q <= '0;
      ptv_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      if (wr_en) begin
        entry_q[wr_idx] <= link_addr;
      end
      sp_q         <= sp_d;
      count_q      <= count_d;
      pop_target_q <= pop_target_d;
      ptv_q        <= ptv_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign tos_valid        = !empty;
  assign tos_addr         = empty ? '0 : top_val;
  assign pop_target_valid = ptv_q;
  assign pop_target       = pop_target_q;
  assign count            = count_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// -----------------------------------------------------------------------------
// tb_return_address_stack
//
// Bench for return_address_stack. Two instances share one set of inputs:
// u_wrap uses WRAP_MODE=1 and u_drop uses WRAP_MODE=0, both with DEPTH=8.
// A queue-based stack model per instance tracks the expected state.
// -----------------------------------------------------------------------------
module tb_return_address_stack;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            flush, op_valid, is_jal, is_jalr;
  logic [4:0]      rd, rs1;
  logic [XLEN-1:0] link_addr;

  logic            w_tos_valid, d_tos_valid;
  logic [XLEN-1:0] w_tos_addr, d_tos_addr;
  logic            w_ptv, d_ptv;
  logic [XLEN-1:0] w_pt, d_pt;
  logic [CW-1:0]   w_count, d_count;
  logic            w_ovf, d_ovf, w_unf, d_unf;

  return_address_stack #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid),
    .is_jal(is_jal), .is_jalr(is_jalr), .rd(rd), .rs1(rs1),
    .link_addr(link_addr), .tos_valid(w_tos_valid), .tos_addr(w_tos_addr),
    .pop_target_valid(w_ptv), .pop_target(w_pt), .count(w_count),
    .overflow(w_ovf), .underflow(w_unf)
  );

  return_address_stack #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP_MODE(0)) u_drop (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid),
    .is_jal(is_jal), .is_jalr(is_jalr), .rd(rd), .rs1(rs1),
    .link_addr(link_addr), .tos_valid(d_tos_valid), .tos_addr(d_tos_addr),
    .pop_target_valid(d_ptv), .pop_target(d_pt), .count(d_count),
    .overflow(d_ovf), .underflow(d_unf)
  );

  // ---------------------------------------------------------------- scoreboard
  int errors = 0;
  int checks = 0;

  // Model stacks: back of the queue is the top of the stack.
  logic [XLEN-1:0] stk_w[$];
  logic [XLEN-1:0] stk_d[$];
  logic            exp_ptv [2];
  logic [XLEN-1:0] exp_pt  [2];
  logic            exp_ovf [2];
  logic            exp_unf [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  localparam int K_NONE = 0, K_PUSH = 1, K_POP = 2, K_PP = 3;

  function automatic int classify(input logic v, input logic j, input logic jr,
                                  input logic [4:0] d, input logic [4:0] s);
    bit ld, ls;
    ld = (d == 5'd1) || (d == 5'd5);
    ls = (s == 5'd1) || (s == 5'd5);
    if (!v || (j == jr)) return K_NONE;
    if (j) return ld ? K_PUSH : K_NONE;
    if (ld && ls && (d != s)) return K_PP;
    if (ld) return K_PUSH;
    if (ls) return K_POP;
    return K_NONE;
  endfunction

  task automatic model_reset();
    stk_w.delete();
    stk_d.delete();
    for (int m = 0; m < 2; m++) begin
      exp_ptv[m] = 1'b0; exp_pt[m] = '0; exp_ovf[m] = 1'b0; exp_unf[m] = 1'b0;
    end
  endtask

  task automatic model_apply(input int m, input logic fl, input int k, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] q[$];
    if (m == 1) q = stk_w; else q = stk_d;
    exp_ptv[m] = 1'b0; exp_ovf[m] = 1'b0; exp_unf[m] = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      case (k)
        K_PUSH: begin
          if (q.size() < DEPTH) q.push_back(a);
          else begin
            exp_ovf[m] = 1'b1;
            if (m == 1) begin
              void'(q.pop_front());
              q.push_back(a);
            end
          end
        end
        K_POP: begin
          if (q.size() > 0) begin
            exp_pt[m] = q.pop_back(); exp_ptv[m] = 1'b1;
          end else exp_unf[m] = 1'b1;
        end
        K_PP: begin
          if (q.size() > 0) begin
            exp_pt[m] = q.pop_back(); exp_ptv[m] = 1'b1;
          end else exp_unf[m] = 1'b1;
          q.push_back(a);
        end
        default: ;
      endcase
    end
    if (m == 1) stk_w = q; else stk_d = q;
  endtask

  task automatic check_all();
    logic [XLEN-1:0] q[$];
    logic [XLEN-1:0] etos;
    for (int m = 0; m < 2; m++) begin
      if (m == 1) q = stk_w; else q = stk_d;
      etos = (q.size() > 0) ? q[$] : '0;
      if (m == 1) begin
        check("wrap.count",     32'(w_count),   32'(q.size()));
        check("wrap.tos_valid", 32'(w_tos_valid), 32'(q.size() > 0));
        check("wrap.tos_addr",  w_tos_addr,     etos);
        check("wrap.ptv",       32'(w_ptv),     32'(exp_ptv[1]));
        check("wrap.pop_target", w_pt,          exp_pt[1]);
        check("wrap.overflow",  32'(w_ovf),     32'(exp_ovf[1]));
        check("wrap.underflow", 32'(w_unf),     32'(exp_unf[1]));
      end else begin
        check("drop.count",     32'(d_count),   32'(q.size()));
        check("drop.tos_valid", 32'(d_tos_valid), 32'(q.size() > 0));
        check("drop.tos_addr",  d_tos_addr,     etos);
        check("drop.ptv",       32'(d_ptv),     32'(exp_ptv[0]));
        check("drop.pop_target", d_pt,          exp_pt[0]);
        check("drop.overflow",  32'(d_ovf),     32'(exp_ovf[0]));
        check("drop.underflow", 32'(d_unf),     32'(exp_unf[0]));
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic fl, input logic v, input logic j, input logic jr,
                      input logic [4:0] r_d, input logic [4:0] r_s, input logic [XLEN-1:0] a);
    int k;
    flush = fl; op_valid = v; is_jal = j; is_jalr = jr;
    rd = r_d; rs1 = r_s; link_addr = a;
    k = classify(v, j, jr, r_d, r_s);
    @(posedge clk);
    model_apply(1, fl, k, a);
    model_apply(0, fl, k, a);
    #1;
    check_all();
    flush = 1'b0; op_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic            fl, v, j, jr;
    logic [4:0]      rd, rs1;
    logic [31:0]     a;
    int              cnt;
    logic [31:0]     tos;
    logic            ptv;
    logic [31:0]     pt;
    logic            unf;
  } vec_t;

  vec_t tbl [17];

  initial begin
    reset = 1'b0;
    flush = 1'b0; op_valid = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    rd = '0; rs1 = '0; link_addr = '0;
    model_reset();

    //            fl v  j  jr rd     rs1    addr    cnt tos      ptv pt       unf
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,5'd1,5'd0,32'd4,  1, 32'd4,  1'b0,32'd0,  1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,5'd0,5'd1,32'd99, 0, 32'd0,  1'b1,32'd4,  1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,5'd0,5'd5,32'd98, 0, 32'd0,  1'b0,32'd4,  1'b1};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,5'd5,5'd0,32'd100,1, 32'd100,1'b0,32'd4,  1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,5'd1,5'd5,32'd200,1, 32'd200,1'b1,32'd100,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,5'd1,5'd0,32'd300,0, 32'd0,  1'b0,32'd100,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,5'd1,5'd1,32'd8,  1, 32'd8,  1'b0,32'd100,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,5'd5,5'd5,32'd12, 2, 32'd12, 1'b0,32'd100,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,5'd1,5'd0,32'd16, 3, 32'd16, 1'b0,32'd100,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,5'd0,5'd0,32'd20, 3, 32'd16, 1'b0,32'd100,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b1,5'd1,5'd0,32'd21, 3, 32'd16, 1'b0,32'd100,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,5'd1,5'd0,32'd22, 3, 32'd16, 1'b0,32'd100,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b1,5'd0,5'd0,32'd23, 3, 32'd16, 1'b0,32'd100,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b1,5'd5,5'd1,32'd24, 3, 32'd24, 1'b1,32'd16, 1'b0};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,32'd0,  0, 32'd0,  1'b0,32'd16, 1'b0};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b1,5'd5,5'd1,32'd40, 1, 32'd40, 1'b0,32'd16, 1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,32'd0,  0, 32'd0,  1'b0,32'd16, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Table-driven directed vectors
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].fl, tbl[i].v, tbl[i].j, tbl[i].jr, tbl[i].rd, tbl[i].rs1, tbl[i].a);
      check($sformatf("tbl%0d.count", i),     32'(w_count),   32'(tbl[i].cnt));
      check($sformatf("tbl%0d.tos", i),       w_tos_addr,     tbl[i].tos);
      check($sformatf("tbl%0d.tos_valid", i), 32'(w_tos_valid), 32'(tbl[i].cnt != 0));
      check($sformatf("tbl%0d.ptv", i),       32'(w_ptv),     32'(tbl[i].ptv));
      check($sformatf("tbl%0d.pt", i),        w_pt,           tbl[i].pt);
      check($sformatf("tbl%0d.unf", i),       32'(w_unf),     32'(tbl[i].unf));
      check($sformatf("tbl%0d.ovf", i),       32'(w_ovf),     32'd0);
      check($sformatf("tbl%0d.drop_count", i), 32'(d_count),  32'(tbl[i].cnt));
      check($sformatf("tbl%0d.drop_pt", i),   d_pt,           tbl[i].pt);
    end

    // Fill past full: 9 pushes of 4,8,..,36
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 32'(4 * i));
      check($sformatf("fill%0d.wrap_ovf", i), 32'(w_ovf), 32'(i == 9));
      check($sformatf("fill%0d.drop_ovf", i), 32'(d_ovf), 32'(i == 9));
    end
    check("fill.wrap_count", 32'(w_count), 32'd8);
    check("fill.drop_count", 32'(d_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 32'd0);
      check($sformatf("drain%0d.wrap_pt", i), w_pt, 32'(36 - 4 * i));
      check($sformatf("drain%0d.drop_pt", i), d_pt, 32'(32 - 4 * i));
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 32'd0);
    check("drain.wrap_unf", 32'(w_unf), 32'd1);
    check("drain.drop_unf", 32'(d_unf), 32'd1);

    // Asynchronous reset between edges
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 32'(1000 + i));
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst.wrap_count", 32'(w_count), 32'd0);
    check("async_rst.drop_count", 32'(d_count), 32'd0);
    check("async_rst.tos_valid",  32'(w_tos_valid), 32'd0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 32'd0);
    check("post_rst.wrap_unf", 32'(w_unf), 32'd1);
    check("post_rst.drop_unf", 32'(d_unf), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r_d, r_s;
      logic       fl, v, j, jr;
      int         sel;
      sel = $urandom_range(0, 3);
      r_d = (sel == 0) ? 5'd1 : (sel == 1) ? 5'd5 : (sel == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 3);
      r_s = (sel == 0) ? 5'd1 : (sel == 1) ? 5'd5 : (sel == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      fl  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 9);
      j   = (sel < 5) || (sel == 9);
      jr  = (sel >= 5);
      step(fl, v, j, jr, r_d, r_s, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
